// File: rtl/sdc_pkg.sv
// Shared register map, command codes, status layout, FSM states and per-drive record.
package sdc_pkg;

    localparam logic [7:0] REG_LBA0   = 8'd0;
    localparam logic [7:0] REG_STATUS = 8'd4;
    localparam logic [7:0] REG_CMD    = 8'd5;
    localparam logic [7:0] REG_DRIVE  = 8'd7;
    localparam logic [7:0] REG_SIZE0  = 8'd8;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int ST_CHANGED = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_MOUNTED = 2;
    localparam int ST_RO      = 3;
    localparam int ST_BUSY    = 4;
    localparam int ST_ERR     = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] lba;
        logic [63:0] size;
        logic        mounted;
        logic        ro;
        logic        changed;
        logic        done;
    } drv_t;

endpackage

// File: rtl/sd_ctrl_mmio_if.sv
// CPU bus and HPS sector-interface signals; slave = controller, master = CPU/HPS side.
interface sd_ctrl_mmio_if #(
    parameter int NUM_DRIVES = 1
);
    logic [8:0]              cpu_addr;
    logic [7:0]              cpu_dout;
    logic                    cpu_rd_n;
    logic                    cpu_wr_n;
    logic                    cpu_mreq_n;
    logic                    reg_cs;
    logic                    buf_cs;
    logic [7:0]              cpu_din;
    logic [NUM_DRIVES-1:0]   img_mounted;
    logic                    img_readonly;
    logic [63:0]             img_size;
    logic [32*NUM_DRIVES-1:0] sd_lba;
    logic [NUM_DRIVES-1:0]   sd_rd;
    logic [NUM_DRIVES-1:0]   sd_wr;
    logic [NUM_DRIVES-1:0]   sd_ack;
    logic [8:0]              sd_buff_addr;
    logic [7:0]              sd_buff_dout;
    logic                    sd_buff_wr;
    logic [7:0]              sd_buff_din;

    modport slave (
        input  cpu_addr, cpu_dout, cpu_rd_n, cpu_wr_n, cpu_mreq_n, reg_cs, buf_cs,
        input  img_mounted, img_readonly, img_size, sd_ack,
        input  sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output cpu_din, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport master (
        output cpu_addr, cpu_dout, cpu_rd_n, cpu_wr_n, cpu_mreq_n, reg_cs, buf_cs,
        output img_mounted, img_readonly, img_size, sd_ack,
        output sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  cpu_din, sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/sdc_sector_buf.sv
// 512x8 true dual-port sector RAM, registered reads on both ports (read-before-write).
module sdc_sector_buf (
    input  logic       clk_sys,
    input  logic [8:0] i_a_addr,
    input  logic       i_a_we,
    input  logic [7:0] i_a_din,
    output logic [7:0] o_a_dout,
    input  logic [8:0] i_b_addr,
    input  logic       i_b_we,
    input  logic [7:0] i_b_din,
    output logic [7:0] o_b_dout
);
    logic [7:0] r_mem [0:511];

    always_ff @(posedge clk_sys) begin
        // HPS port owns the address when both sides write it in the same cycle
        if (i_a_we && !(i_b_we && (i_b_addr == i_a_addr)))
            r_mem[i_a_addr] <= i_a_din;
        if (i_b_we)
            r_mem[i_b_addr] <= i_b_din;
        o_a_dout <= r_mem[i_a_addr];
        o_b_dout <= r_mem[i_b_addr];
    end
endmodule

// File: rtl/sd_ctrl_mmio.sv
// Memory-mapped multi-drive SD sector controller with sector buffer, timeout and read-to-clear status.
// Define SDC_LBA_AUTOINC_EN to advance the active drive's LBA after each completed transfer.
module sd_ctrl_mmio
    import sdc_pkg::*;
#(
    parameter int          NUM_DRIVES     = 1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter int          DRV_W          = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
)(
    input logic           clk_sys,
    input logic           reset,
    sd_ctrl_mmio_if.slave bus
);
    drv_t [NUM_DRIVES-1:0]    r_drv;
    state_t                   r_state;
    logic [DRV_W-1:0]         r_sel;
    logic [DRV_W-1:0]         r_act;
    logic                     r_err;
    logic [23:0]              r_cnt;
    logic [NUM_DRIVES-1:0]    r_sd_rd;
    logic [NUM_DRIVES-1:0]    r_sd_wr;
    logic                     r_rd_n_q;
    logic                     r_wr_n_q;
    logic                     r_stat_rd;
    logic [7:0]               r_stat_snap;

    logic [7:0]               w_off;
    logic                     w_reg_acc, w_reg_wr, w_rd_fall, w_rd_rise, w_clr, w_busy;
    logic                     w_cmd_valid, w_cmd_is_wr, w_cmd_ok, w_act_ack;
    drv_t                     w_cur;
    logic [7:0]               w_status, w_reg_dat, w_buf_q, w_hps_q;
    logic [32*NUM_DRIVES-1:0] w_lba;

    assign w_off       = bus.cpu_addr[7:0];
    assign w_reg_acc   = bus.reg_cs && !bus.cpu_mreq_n;
    assign w_reg_wr    = w_reg_acc && r_wr_n_q && !bus.cpu_wr_n;
    assign w_rd_fall   = r_rd_n_q && !bus.cpu_rd_n;
    assign w_rd_rise   = !r_rd_n_q && bus.cpu_rd_n;
    assign w_clr       = w_rd_rise && r_stat_rd;
    assign w_busy      = (r_state != S_IDLE);
    assign w_cmd_valid = w_reg_wr && (w_off == REG_CMD) &&
                         ((bus.cpu_dout == CMD_READ) || (bus.cpu_dout == CMD_WRITE));
    assign w_cmd_is_wr = (bus.cpu_dout == CMD_WRITE);
    assign w_cmd_ok    = w_cur.mounted && !(w_cmd_is_wr && w_cur.ro);

    // Compare-based lookup keeps out-of-range select values harmless
    always_comb begin
        w_cur     = '0;
        w_act_ack = 1'b0;
        w_lba     = '0;
        for (int d = 0; d < NUM_DRIVES; d++) begin
            if (r_sel == DRV_W'(d)) w_cur = r_drv[d];
            if (r_act == DRV_W'(d)) w_act_ack = bus.sd_ack[d];
            w_lba[32*d +: 32] = r_drv[d].lba;
        end
    end

    always_comb begin
        w_status              = 8'h00;
        w_status[ST_CHANGED]  = w_cur.changed;
        w_status[ST_DONE]     = w_cur.done;
        w_status[ST_MOUNTED]  = w_cur.mounted;
        w_status[ST_RO]       = w_cur.ro;
        w_status[ST_BUSY]     = w_busy;
        w_status[ST_ERR]      = r_err;
    end

    always_comb begin
        w_reg_dat = 8'h00;
        if (w_off[7:2] == REG_LBA0[7:2])
            w_reg_dat = 8'(w_cur.lba >> {~w_off[1:0], 3'b000});
        else if (w_off == REG_STATUS)
            w_reg_dat = (r_stat_rd && !bus.cpu_rd_n) ? r_stat_snap : w_status;
        else if (w_off == REG_DRIVE)
            w_reg_dat = 8'(r_sel);
        else if (w_off[7:3] == REG_SIZE0[7:3])
            w_reg_dat = 8'(w_cur.size >> {~w_off[2:0], 3'b000});
    end

    assign bus.cpu_din     = bus.reg_cs ? w_reg_dat : (bus.buf_cs ? w_buf_q : 8'h00);
    assign bus.sd_lba      = w_lba;
    assign bus.sd_rd       = r_sd_rd;
    assign bus.sd_wr       = r_sd_wr;
    assign bus.sd_buff_din = w_hps_q;

    sdc_sector_buf u_buf (
        .clk_sys  (clk_sys),
        .i_a_addr (bus.cpu_addr),
        .i_a_we   (bus.buf_cs && !bus.cpu_mreq_n && !bus.cpu_wr_n),
        .i_a_din  (bus.cpu_dout),
        .o_a_dout (w_buf_q),
        .i_b_addr (bus.sd_buff_addr),
        .i_b_we   (bus.sd_buff_wr),
        .i_b_din  (bus.sd_buff_dout),
        .o_b_dout (w_hps_q)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_rd_n_q    <= 1'b1;
            r_wr_n_q    <= 1'b1;
            r_stat_rd   <= 1'b0;
            r_stat_snap <= 8'h00;
        end else begin
            r_rd_n_q <= bus.cpu_rd_n;
            r_wr_n_q <= bus.cpu_wr_n;
            if (w_rd_fall && w_reg_acc && (w_off == REG_STATUS)) begin
                r_stat_rd   <= 1'b1;
                r_stat_snap <= w_status;
            end else if (w_rd_rise) begin
                r_stat_rd <= 1'b0;
            end
        end
    end

    // Clears are written first so that same-cycle set events override them
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_drv   <= '0;
            r_sel   <= '0;
            r_act   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_sd_rd <= '0;
            r_sd_wr <= '0;
        end else begin
            if (w_clr) r_err <= 1'b0;
            if (w_reg_wr && (w_off == REG_DRIVE) && !w_busy)
                r_sel <= bus.cpu_dout[DRV_W-1:0];
            for (int d = 0; d < NUM_DRIVES; d++) begin
                if (w_reg_wr && (w_off[7:2] == REG_LBA0[7:2]) && (r_sel == DRV_W'(d)))
                    r_drv[d].lba[{~w_off[1:0], 3'b000} +: 8] <= bus.cpu_dout;
                if (w_clr && (r_sel == DRV_W'(d))) begin
                    r_drv[d].done    <= 1'b0;
                    r_drv[d].changed <= 1'b0;
                end
                if (bus.img_mounted[d]) begin
                    r_drv[d].size    <= bus.img_size;
                    r_drv[d].ro      <= bus.img_readonly;
                    r_drv[d].mounted <= (bus.img_size != 64'd0);
                    r_drv[d].changed <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_valid) begin
                        if (w_cmd_ok) begin
                            r_state <= S_REQ;
                            r_act   <= r_sel;
                            r_cnt   <= '0;
                            for (int d = 0; d < NUM_DRIVES; d++) begin
                                if (r_sel == DRV_W'(d)) begin
                                    r_sd_wr[d] <= w_cmd_is_wr;
                                    r_sd_rd[d] <= !w_cmd_is_wr;
                                end
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (w_cmd_valid) r_err <= 1'b1;
                    if (w_act_ack) begin
                        r_state <= S_XFER;
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                    end else if (r_cnt == TIMEOUT_CYCLES - 24'd1) begin
                        r_state <= S_IDLE;
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_XFER: begin
                    if (w_cmd_valid) r_err <= 1'b1;
                    if (!w_act_ack) begin
                        r_state <= S_IDLE;
                        for (int d = 0; d < NUM_DRIVES; d++) begin
                            if (r_act == DRV_W'(d)) begin
                                r_drv[d].done <= 1'b1;
`ifdef SDC_LBA_AUTOINC_EN
                                r_drv[d].lba  <= r_drv[d].lba + 32'd1;
`else
                                r_drv[d].lba  <= r_drv[d].lba;
`endif
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_ctrl_mmio.sv
// Directed bench for sd_ctrl_mmio: two drives, 100-cycle request timeout.
module tb_sd_ctrl_mmio;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rd;
    int   n;

    always #5 clk = ~clk;

    sd_ctrl_mmio_if #(.NUM_DRIVES(2)) bus ();

    sd_ctrl_mmio #(.NUM_DRIVES(2), .TIMEOUT_CYCLES(24'd100)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        bus.cpu_addr = {1'b0, a}; bus.cpu_dout = d;
        bus.reg_cs = 1'b1; bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0;
        cyc(2);
        bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b1; bus.reg_cs = 1'b0;
        cyc(1);
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
        bus.cpu_addr = {1'b0, a};
        bus.reg_cs = 1'b1; bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0;
        cyc(1);
        @(negedge clk);
        d = bus.cpu_din;
        @(posedge clk); #1;
        bus.cpu_rd_n = 1'b1;
        cyc(1);
        bus.reg_cs = 1'b0; bus.cpu_mreq_n = 1'b1;
    endtask

    task automatic buf_rd(input logic [8:0] a, output logic [7:0] d);
        bus.cpu_addr = a;
        bus.buf_cs = 1'b1; bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0;
        cyc(1);
        @(negedge clk);
        d = bus.cpu_din;
        @(posedge clk); #1;
        bus.buf_cs = 1'b0; bus.cpu_mreq_n = 1'b1; bus.cpu_rd_n = 1'b1;
    endtask

    task automatic mount(input logic [1:0] m, input logic [63:0] sz, input logic ro);
        bus.img_size = sz; bus.img_readonly = ro; bus.img_mounted = m;
        cyc(1);
        bus.img_mounted = 2'b00;
    endtask

    initial begin
        bus.cpu_addr = '0; bus.cpu_dout = '0;
        bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b1;
        bus.reg_cs = 1'b0; bus.buf_cs = 1'b0;
        bus.img_mounted = '0; bus.img_readonly = 1'b0; bus.img_size = '0;
        bus.sd_ack = '0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0; bus.sd_buff_wr = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        chk("rst_sd_rd", 64'(bus.sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(bus.sd_wr), 64'd0);
        chk("rst_sd_lba", 64'(bus.sd_lba), 64'd0);
        for (int i = 0; i < 16; i++) begin
            reg_rd(8'(i), rd);
            chk($sformatf("rst_reg%0d", i), 64'(rd), 64'h00);
        end

        // Mount drive 0, read-to-clear of changed
        mount(2'b01, 64'h400, 1'b0);
        reg_rd(8'd4, rd); chk("status_mount", 64'(rd), 64'h05);
        reg_rd(8'd4, rd); chk("status_cleared", 64'(rd), 64'h04);
        reg_rd(8'd14, rd); chk("size_byte14", 64'(rd), 64'h04);
        reg_rd(8'd15, rd); chk("size_byte15", 64'(rd), 64'h00);

        // Sector read on drive 0
        reg_wr(8'd0, 8'h00); reg_wr(8'd1, 8'h00); reg_wr(8'd2, 8'h00); reg_wr(8'd3, 8'h10);
        reg_rd(8'd3, rd); chk("lba_byte3", 64'(rd), 64'h10);
        reg_wr(8'd5, 8'h01);
        chk("rd_req_high", 64'(bus.sd_rd), 64'b01);
        cyc(5);
        bus.sd_ack = 2'b01;
        cyc(1);
        chk("rd_req_drop_on_ack", 64'(bus.sd_rd), 64'b00);
        for (int i = 0; i < 512; i++) begin
            bus.sd_buff_addr = 9'(i); bus.sd_buff_dout = 8'(i); bus.sd_buff_wr = 1'b1;
            cyc(1);
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack = 2'b00;
        cyc(2);
        reg_rd(8'd4, rd); chk("status_done", 64'(rd), 64'h06);
        reg_rd(8'd4, rd); chk("status_done_cleared", 64'(rd), 64'h04);
        buf_rd(9'h000, rd); chk("buf_000", 64'(rd), 64'h00);
        buf_rd(9'h055, rd); chk("buf_055", 64'(rd), 64'h55);
        buf_rd(9'h1FF, rd); chk("buf_1FF", 64'(rd), 64'hFF);
        bus.sd_buff_addr = 9'h1AB;
        cyc(1);
        @(negedge clk);
        chk("sd_buff_din", 64'(bus.sd_buff_din), 64'hAB);
        reg_rd(8'd3, rd);
`ifdef SDC_LBA_AUTOINC_EN
        chk("lba_after_xfer", 64'(rd), 64'h11);
`else
        chk("lba_after_xfer", 64'(rd), 64'h10);
`endif

        // Simultaneous CPU and HPS write to one address, then a CPU-only write
        @(posedge clk); #1;
        bus.cpu_addr = 9'h020; bus.cpu_dout = 8'hEE;
        bus.buf_cs = 1'b1; bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0;
        bus.sd_buff_addr = 9'h020; bus.sd_buff_dout = 8'h77; bus.sd_buff_wr = 1'b1;
        cyc(1);
        bus.sd_buff_wr = 1'b0;
        bus.cpu_addr = 9'h021; bus.cpu_dout = 8'h33;
        cyc(1);
        bus.cpu_wr_n = 1'b1; bus.buf_cs = 1'b0; bus.cpu_mreq_n = 1'b1;
        cyc(1);
        buf_rd(9'h020, rd); chk("buf_hps_wins", 64'(rd), 64'h77);
        buf_rd(9'h021, rd); chk("buf_cpu_write", 64'(rd), 64'h33);

        // Write to read-only drive 1 is rejected
        mount(2'b10, 64'h200, 1'b1);
        reg_wr(8'd7, 8'h01);
        reg_rd(8'd7, rd); chk("drive_sel1", 64'(rd), 64'h01);
        reg_wr(8'd5, 8'h02);
        cyc(2);
        chk("ro_no_sd_wr", 64'(bus.sd_wr), 64'b00);
        reg_rd(8'd4, rd); chk("status_ro_err", 64'(rd), 64'h2D);

        // Timeout on drive 0
        reg_wr(8'd7, 8'h00);
        @(posedge clk); #1;
        bus.cpu_addr = {1'b0, 8'd5}; bus.cpu_dout = 8'h01;
        bus.reg_cs = 1'b1; bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0;
        @(posedge clk); #1;
        bus.cpu_wr_n = 1'b1; bus.cpu_mreq_n = 1'b1; bus.reg_cs = 1'b0;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.sd_rd[0]) n++;
            else break;
        end
        chk("timeout_req_cycles", 64'(n), 64'd100);
        cyc(1);
        reg_rd(8'd4, rd); chk("status_timeout", 64'(rd), 64'h24);

        // Command while busy, LBA write during transfer, reset mid-transfer
        reg_wr(8'd5, 8'h01);
        bus.sd_ack = 2'b01;
        cyc(2);
        reg_wr(8'd5, 8'h02);
        chk("busy_no_sd_wr", 64'(bus.sd_wr), 64'b00);
        reg_wr(8'd7, 8'h01);
        reg_rd(8'd7, rd); chk("sel_locked_busy", 64'(rd), 64'h00);
        reg_rd(8'd4, rd); chk("status_busy_err", 64'(rd), 64'h34);
        reg_wr(8'd3, 8'h55);
        chk("lba_write_in_xfer", 64'(bus.sd_lba[31:0]), 64'h55);
        rst = 1'b1;
        #1;
        chk("rst_mid_sd_rd", 64'(bus.sd_rd), 64'd0);
        chk("rst_mid_sd_wr", 64'(bus.sd_wr), 64'd0);
        chk("rst_mid_sd_lba", 64'(bus.sd_lba), 64'd0);
        bus.sd_ack = 2'b00;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        reg_rd(8'd4, rd); chk("rst_mid_status", 64'(rd), 64'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_ctrl_mmio.md
# sd_ctrl_mmio

Memory-mapped multi-drive SD block controller for the Z80 harness. Sits between the CPU bus decode and the HPS sector interface and owns a 512-byte sector buffer. Provides per-drive LBA, image size, mount and readonly tracking, plus single-sector read and write commands. Includes request timeout, sticky status with read-to-clear, and optional LBA auto-increment.

## Interface
Parameters:
- NUM_DRIVES, 1, number of HPS drives (1..4)
- TIMEOUT_CYCLES, 24'd12_000_000, clk_sys cycles allowed from request to first sd_ack
- DRV_W, $clog2(NUM_DRIVES) min 1, drive-select width (derived)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_addr  in  9  CPU address low bits
- cpu_dout  in  8  CPU write data
- cpu_rd_n, cpu_wr_n, cpu_mreq_n  in  1  Z80 strobes
- reg_cs  in  1  register window select, uses cpu_addr[7:0]
- buf_cs  in  1  buffer window select, uses cpu_addr[8:0]
- cpu_din  out  8  read data for the CPU mux
- img_mounted  in  NUM_DRIVES  per-drive mount pulse
- img_readonly  in  1  readonly flag, valid with the pulse
- img_size  in  64  image size in bytes, valid with the pulse
- sd_lba  out  32*NUM_DRIVES  per-drive LBA
- sd_rd, sd_wr  out  NUM_DRIVES  request strobes
- sd_ack  in  NUM_DRIVES  HPS transfer in progress
- sd_buff_addr  in  9  HPS buffer address
- sd_buff_dout  in  8  HPS write data into the buffer
- sd_buff_wr  in  1  HPS buffer write
- sd_buff_din  out  8  buffer data to HPS, one-cycle latency

## Operation
Bus strobe edges:
- Previous cpu_rd_n and cpu_wr_n are registered. Both reset to 1.
- Register writes act on a cpu_wr_n falling edge qualified by reg_cs and !cpu_mreq_n. Exactly one clk_sys pulse results per access.

Register map (reg_cs):
- 0–3: LBA of the selected drive, big-endian. Byte 0 is bits 31:24. Read/write.
- 4: STATUS (read) = {2'b0, err, busy, ro, mounted, done, changed}. Fields are for the selected drive, except busy and err, which are global.
- 5: COMMAND (write). Value 8'h01 = read, 8'h02 = write. Other values are ignored.
- 7: DRIVE select. Read/write, low DRV_W bits used. Writes are ignored while busy.
- 8–15: latched img_size of the selected drive, big-endian.
- Unmapped offsets read 8'h00.

Buffer window (buf_cs):
- CPU writes when buf_cs && !cpu_mreq_n && !cpu_wr_n.
- Reads return buffer data with one-cycle latency.

Per-drive mount tracking:
- On img_mounted[d]: size[d] <= img_size; ro[d] <= img_readonly; mounted[d] <= (img_size != 0); changed[d] <= 1.

Command FSM (IDLE, REQ, XFER):
- Command accepted in IDLE:
  - Read requires mounted.
  - Write requires mounted and !ro.
  - A rejected command sets err, issues no request, and stays in IDLE.
- Command while busy: ignored and sets err.
- IDLE→REQ: assert sd_rd[sel] or sd_wr[sel]; clear the timeout counter. busy = (state != IDLE).
- REQ→XFER: on sd_ack[sel] high. The request is deasserted in the same cycle.
- REQ→IDLE: when the counter reaches TIMEOUT_CYCLES-1. Deassert the request, set err, leave done clear.
- XFER→IDLE: on sd_ack[sel] falling. Set done[sel].
- The active drive index is latched at command accept.

Read-to-clear:
- A STATUS read snapshots STATUS on the cpu_rd_n falling edge. cpu_din returns the snapshot while cpu_rd_n is low.
- On the cpu_rd_n rising edge, clear done[sel], changed[sel] and err.
- A set event in the same cycle as the clear wins.

## Timing
Reset values:
- sd_lba = 0, sd_rd = 0, sd_wr = 0, drive select = 0.
- All flags 0; size = 0; state IDLE.
- Buffer contents are undefined.

Latency:
- Request asserts one cycle after the accepting wr_n edge.
- done sets one cycle after the sd_ack fall.
- Register reads are combinational from registers. Buffer and sd_buff_din reads have one-cycle latency.

Boundary and concurrency rules:
- Simultaneous HPS and CPU writes to the same buffer address: HPS wins.
- img_mounted on the active drive mid-transfer updates mount state only; the FSM continues.
- The LBA register of the active drive is writable during a transfer. The HPS samples it per its own protocol.
- reset mid-transfer returns to IDLE immediately and drops requests.

## Configuration
- SDC_LBA_AUTOINC_EN defined: on XFER→IDLE, the active drive's LBA increments by 1, wrapping 32'hFFFFFFFF→0. The increment is applied in the same cycle done sets, and wins over a coincident CPU LBA write.
- Not defined: the LBA changes only by CPU writes.

## Structure
- Package sdc_pkg holds:
  - register offsets
  - COMMAND codes
  - STATUS bit positions
  - FSM state enum
  - per-drive record typedef (lba, size, mounted, ro, changed, done)
- Sub-module sdc_sector_buf: a 512×8 true dual-port synchronous RAM. Port A serves the CPU, port B the HPS.

## Test plan
- Reset, then read offsets 0–15 → all 8'h00. sd_rd = sd_wr = 0.
- Mount drive 0 with size 64'h400 and readonly 0. Read STATUS → 8'h05. Read STATUS again → 8'h04.
- Set LBA 32'h00000010, issue COMMAND 8'h01, HPS acks after 5 cycles and writes 512 bytes of value i[7:0]. Check:
  - sd_rd[0] pulses and drops on ack
  - STATUS = 8'h06 after the ack falls
  - buffer reads return i[7:0]
  - with SDC_LBA_AUTOINC_EN, LBA reads 32'h00000011
- Mount drive 1 with readonly 1, select drive 1, issue write → no sd_wr, STATUS err bit set.
- Issue read with no sd_ack and TIMEOUT_CYCLES = 100 → request drops at cycle 100, err = 1, done = 0, busy = 0.
- Issue a second COMMAND while busy → ignored, err = 1. Then assert reset mid-XFER → all outputs return to reset values.
